pc_fetch_unit: RTL and testbench

- Owns the program counter for the core and drives `count` into `instruction_memory`.
- `instruction_memory` is combinational, so the instruction selected by `count` is valid in the same cycle.
- Sequences reset-vector boot, sequential advance, stall hold and branch/jump redirect.
- Traps misaligned or out-of-image addresses into a sticky fault state instead of letting the memory index out of range.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/pc_range_check.sv | 27 ++
 rtl/pc_fetch_unit.sv | 117 +++++++++++
 tb/tb_pc_fetch_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the PC fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch sequencer state, encoded as explicit-width constants
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_BOOT = 2'd0;
    localparam fetch_state_t ST_RUN  = 2'd1;
    localparam fetch_state_t ST_HALT = 2'd2;

    // Recorded trap reason
    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_RANGE    = 2'b10
    } fault_cause_t;

    // Default boot address and image base
    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h8000_0000;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/pc_range_check.sv
`default_nettype none
// ============================================================================
// Module      : pc_range_check
// Description : Combinational alignment and image-bounds check of an address.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_range_check #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] depth,
    output logic             misaligned,
    output logic             out_of_range
);

    logic [WIDTH-1:0] word_index;

    // Word offset from the image base; wraps when addr < base, which the
    // explicit below-base term catches.
    assign word_index = (addr - base) >> 2;

    assign misaligned   = (addr[1:0] != 2'b00);
    assign out_of_range = (addr < base) || (word_index >= depth);

endmodule : pc_range_check
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program counter sequencer: boot, advance, stall, redirect,
//               and sticky trapping of illegal fetch addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VEC  = WIDTH'(DEFAULT_RESET_VEC),
    parameter int               IMEM_DEPTH = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic [WIDTH-1:0] count,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [31:0]      fetch_cnt,
    output logic             fault,
    output logic [WIDTH-1:0] fault_pc,
    output logic [1:0]       fault_cause
);

    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(IMEM_DEPTH);

    fetch_state_t state;
    logic         tgt_misaligned;
    logic         tgt_out_of_range;
    logic         seq_misaligned;
    logic         seq_out_of_range;

    assign pc_plus4    = count + WIDTH'(4);
    assign fetch_valid = (state == ST_RUN);

    pc_range_check #(.WIDTH(WIDTH)) u_tgt_chk (
        .addr         (redirect_target),
        .base         (RESET_VEC),
        .depth        (DEPTH_W),
        .misaligned   (tgt_misaligned),
        .out_of_range (tgt_out_of_range)
    );

    pc_range_check #(.WIDTH(WIDTH)) u_seq_chk (
        .addr         (pc_plus4),
        .base         (RESET_VEC),
        .depth        (DEPTH_W),
        .misaligned   (seq_misaligned),
        .out_of_range (seq_out_of_range)
    );

    // FSM, PC register, fetch counter and sticky fault capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_BOOT;
            count       <= RESET_VEC;
            fetch_cnt   <= 32'd0;
            fault       <= 1'b0;
            fault_pc    <= '0;
            fault_cause <= CAUSE_NONE;
        end else begin
            case (state)
                ST_BOOT: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    // Accepted fetch: counts even when a redirect or a
                    // trap is taken on the same edge.
                    if (!stall) begin
                        fetch_cnt <= fetch_cnt + 32'd1;
                    end
                    if (redirect_valid) begin
                        if (tgt_misaligned) begin
                            state       <= ST_HALT;
                            fault       <= 1'b1;
                            fault_pc    <= redirect_target;
                            fault_cause <= CAUSE_MISALIGN;
                        end else if (tgt_out_of_range) begin
                            state       <= ST_HALT;
                            fault       <= 1'b1;
                            fault_pc    <= redirect_target;
                            fault_cause <= CAUSE_RANGE;
                        end else begin
                            count <= redirect_target;
                        end
                    end else if (!stall) begin
                        // count is always aligned, so only the range trap
                        // can fire here in practice.
                        if (seq_misaligned) begin
                            state       <= ST_HALT;
                            fault       <= 1'b1;
                            fault_pc    <= pc_plus4;
                            fault_cause <= CAUSE_MISALIGN;
                        end else if (seq_out_of_range) begin
                            state       <= ST_HALT;
                            fault       <= 1'b1;
                            fault_pc    <= pc_plus4;
                            fault_cause <= CAUSE_RANGE;
                        end else begin
                            count <= pc_plus4;
                        end
                    end
                end
                default: begin
                    // HALT (and any unused encoding) holds until reset
                    state <= ST_HALT;
                end
            endcase
        end
    end

endmodule : pc_fetch_unit
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Scoreboard bench for pc_fetch_unit with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam logic [31:0] RV    = 32'h8000_0000;
    localparam int          DEPTH = 30;
    localparam logic [31:0] LAST  = 32'h8000_0074;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic [31:0] count;
    logic        fetch_valid;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_cnt;
    logic        fault;
    logic [31:0] fault_pc;
    logic [1:0]  fault_cause;

    pc_fetch_unit #(.WIDTH(32), .RESET_VEC(RV), .IMEM_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .count           (count),
        .fetch_valid     (fetch_valid),
        .pc_plus4        (pc_plus4),
        .fetch_cnt       (fetch_cnt),
        .fault           (fault),
        .fault_pc        (fault_pc),
        .fault_cause     (fault_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] count;
        logic        fetch_valid;
        logic [31:0] pc_plus4;
        logic [31:0] fetch_cnt;
        logic        fault;
        logic [31:0] fault_pc;
        logic [1:0]  fault_cause;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: mode 0 = booting, 1 = fetching, 2 = trapped
    int          m_mode  = 0;
    logic [31:0] m_pc    = RV;
    logic [31:0] m_cnt   = 0;
    logic        m_fault = 0;
    logic [31:0] m_fpc   = 0;
    logic [1:0]  m_cause = 0;

    function automatic bit in_image(input logic [31:0] a);
        return (a >= RV) && (a <= LAST);
    endfunction

    task automatic trap(input logic [31:0] a, input logic [1:0] c);
        m_mode = 2; m_fault = 1; m_fpc = a; m_cause = c;
    endtask

    task automatic model(input logic r, input logic s, input logic rv,
                         input logic [31:0] t);
        logic [31:0] nxt;
        if (r) begin
            m_mode = 0; m_pc = RV; m_cnt = 0;
            m_fault = 0; m_fpc = 0; m_cause = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (!s) m_cnt = m_cnt + 1;
            if (rv) begin
                if (t % 4 != 0)       trap(t, 2'b01);
                else if (!in_image(t)) trap(t, 2'b10);
                else                   m_pc = t;
            end else if (!s) begin
                nxt = m_pc + 32'd4;
                if (!in_image(nxt)) trap(nxt, 2'b10);
                else                m_pc = nxt;
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic rv,
                        input logic [31:0] t);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; redirect_valid = rv; redirect_target = t;
        model(r, s, rv, t);
        e.count       = m_pc;
        e.fetch_valid = (m_mode == 1);
        e.pc_plus4    = m_pc + 32'd4;
        e.fetch_cnt   = m_cnt;
        e.fault       = m_fault;
        e.fault_pc    = m_fpc;
        e.fault_cause = m_cause;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs after each edge with the queued entry
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("count",       count,               e.count);
            chk("fetch_valid", 32'(fetch_valid),    32'(e.fetch_valid));
            chk("pc_plus4",    pc_plus4,            e.pc_plus4);
            chk("fetch_cnt",   fetch_cnt,           e.fetch_cnt);
            chk("fault",       32'(fault),          32'(e.fault));
            chk("fault_pc",    fault_pc,            e.fault_pc);
            chk("fault_cause", 32'(fault_cause),    32'(e.fault_cause));
        end
    end

    function automatic logic [31:0] rand_target();
        int k;
        k = $urandom_range(0, 9);
        if (k < 5)      return RV + 32'(4 * $urandom_range(0, DEPTH - 1));
        else if (k < 7) return RV + 32'(4 * $urandom_range(0, DEPTH - 1))
                             + 32'($urandom_range(1, 3));
        else if (k < 8) return 32'($urandom_range(0, 32'h7FFF_FFFF)) & ~32'h3;
        else if (k < 9) return LAST + 32'd4 + 32'(4 * $urandom_range(0, 1000));
        else            return 32'hFFFF_FFFC;
    endfunction

    initial begin
        // Reset and release, run sequentially to 0x8000_0010
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);                         // BOOT -> RUN
        repeat (4) step(0, 0, 0, 0);              // up to 0x10
        repeat (3) step(0, 1, 0, 0);              // stall holds
        step(0, 0, 0, 0);                         // resume 0x14
        step(0, 1, 1, 32'h8000_0040);             // redirect beats stall
        step(0, 0, 0, 0);

        // Misaligned redirect, then ignored redirect while halted
        step(0, 0, 1, 32'h8000_0042);
        step(0, 0, 1, 32'h8000_0000);
        step(0, 0, 0, 0);

        // Redirect just past the image end
        step(1, 0, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 1, 32'h8000_0078);
        step(0, 0, 0, 0);

        // Redirect just below the base
        step(1, 0, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 1, 32'h7FFF_FFFC);
        step(0, 0, 0, 0);

        // Misaligned and out of range together: misaligned wins
        step(1, 0, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 1, 32'h0000_0003);

        // Sequential run off the end of the image
        step(1, 0, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 1, 32'h8000_0070);
        step(0, 0, 0, 0);                         // 0x74
        step(0, 0, 0, 0);                         // trap at 0x78
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);                         // reset from HALT
        step(0, 0, 0, 0);

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            logic r, s, rv;
            r  = ($urandom_range(0, 99) < 4);
            s  = ($urandom_range(0, 99) < 30);
            rv = ($urandom_range(0, 99) < 20);
            step(r, s, rv, rand_target());
        end

        // Drain the scoreboard within a bounded number of edges
        step(0, 0, 0, 0);
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pc_fetch_unit
`default_nettype wire
